uart_rx_bps_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync2.sv | 27 ++
 rtl/uart_rx_bps_ctrl.sv | 151 +++++++++++++++
 tb/tb_uart_rx_bps_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive sequencer states, divisor limits, frame
// geometry and the reset-divisor helper. Imported by the UART RX/TX blocks.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HALF,
      BITS,
      STOP,
      WAIT_REL
   } uart_state_e;

   // Smallest legal clocks-per-bit; keeps (div>>1)-1 and div-1 non-negative.
   localparam int unsigned DIV_MIN              = 4;
   localparam int unsigned UART_DATA_BITS       = 8;
   localparam int unsigned UART_FLAGS_PER_FRAME = 9;

   // Clocks per bit for a given clock frequency and baud rate (truncating).
   function automatic int unsigned default_div(input int unsigned clk_freq,
                                               input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous serial line.
// Both flops reset to 1 so an idle (high) UART line reads as idle after reset.
// Ports:
//   clk - system clock
//   rst - synchronous, active-high reset
//   d   - asynchronous input
//   q   - synchronised output (two cycles of latency)
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_bps_ctrl.sv
// Baud-rate / sampling sequencer for the UART receiver.
// On a start request it emits nine single-cycle mid-bit strobes (start bit plus
// eight data bits), then samples the stop bit itself and reports done or
// framing error. A runtime divisor update is applied at the next frame start.
// Ports:
//   CLK_50M       - system clock
//   RST           - synchronous, active-high reset
//   UART_RX       - raw serial line (synchronised internally)
//   rx_bps_start  - receiver request, held high for the whole frame
//   div_load      - one-cycle strobe capturing div_value (clamped to DIV_MIN)
//   div_value     - new clocks-per-bit value
//   rx_bps_flag   - one-cycle mid-bit sample strobe
//   rx_busy       - high whenever the sequencer is not idle
//   rx_frame_done - one-cycle pulse, stop bit was 1
//   rx_frame_err  - one-cycle pulse, stop bit was 0
//   div_cur       - divisor used by the current or next frame
module uart_rx_bps_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ     = 50_000_000,
   parameter int unsigned BAUD_DEFAULT = 9600,
   parameter int unsigned DIV_W        = 16
) (
   input  logic             CLK_50M,
   input  logic             RST,
   input  logic             UART_RX,
   input  logic             rx_bps_start,
   input  logic             div_load,
   input  logic [DIV_W-1:0] div_value,
   output logic             rx_bps_flag,
   output logic             rx_busy,
   output logic             rx_frame_done,
   output logic             rx_frame_err,
   output logic [DIV_W-1:0] div_cur
);

   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(default_div(CLK_FREQ, BAUD_DEFAULT));
   localparam logic [DIV_W-1:0] DIV_LO  = DIV_W'(DIV_MIN);
   localparam logic [3:0]       LAST_BIT = 4'(UART_FLAGS_PER_FRAME - 1);

   uart_state_e      state, state_nxt;
   logic [DIV_W-1:0] cnt, cnt_nxt;
   logic [3:0]       bitn, bitn_nxt;
   logic [DIV_W-1:0] div_pend;
   logic [DIV_W-1:0] half_m1, full_m1;
   logic             flag_nxt;
   logic             smp_nxt;
   logic             start_frame;
   logic             stop_smp;
   logic             stop_bit;
   logic             rx_s;

   uart_sync2 u_sync (
      .clk (CLK_50M),
      .rst (RST),
      .d   (UART_RX),
      .q   (rx_s)
   );

   assign half_m1 = (div_cur >> 1) - DIV_W'(1);
   assign full_m1 = div_cur - DIV_W'(1);
   assign rx_busy = (state != IDLE);

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bitn_nxt    = bitn;
      flag_nxt    = 1'b0;
      smp_nxt     = 1'b0;
      start_frame = 1'b0;
      case (state)
         IDLE: begin
            if (rx_bps_start) begin
               state_nxt   = HALF;
               cnt_nxt     = '0;
               bitn_nxt    = '0;
               start_frame = 1'b1;
            end
         end
         HALF: begin
            if (!rx_bps_start) begin
               state_nxt = IDLE;
            end else if (cnt == half_m1) begin
               flag_nxt  = 1'b1;
               bitn_nxt  = 4'd1;
               cnt_nxt   = '0;
               state_nxt = BITS;
            end else begin
               cnt_nxt = cnt + DIV_W'(1);
            end
         end
         BITS: begin
            if (!rx_bps_start) begin
               state_nxt = IDLE;
            end else if (cnt == full_m1) begin
               flag_nxt = 1'b1;
               bitn_nxt = bitn + 4'd1;
               cnt_nxt  = '0;
               if (bitn == LAST_BIT) state_nxt = STOP;
            end else begin
               cnt_nxt = cnt + DIV_W'(1);
            end
         end
         STOP: begin
            if (!rx_bps_start) begin
               state_nxt = IDLE;
            end else if (cnt == full_m1) begin
               smp_nxt   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = WAIT_REL;
            end else begin
               cnt_nxt = cnt + DIV_W'(1);
            end
         end
         WAIT_REL: begin
            if (!rx_bps_start) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK_50M) begin
      if (RST) begin
         state         <= IDLE;
         cnt           <= '0;
         bitn          <= '0;
         div_cur       <= DIV_RST;
         div_pend      <= DIV_RST;
         rx_bps_flag   <= 1'b0;
         stop_smp      <= 1'b0;
         stop_bit      <= 1'b1;
         rx_frame_done <= 1'b0;
         rx_frame_err  <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         bitn        <= bitn_nxt;
         rx_bps_flag <= flag_nxt;
         stop_smp    <= smp_nxt;
         if (smp_nxt) stop_bit <= rx_s;
         // Stop bit is captured one edge before the result pulse is issued.
         rx_frame_done <= stop_smp & stop_bit;
         rx_frame_err  <= stop_smp & ~stop_bit;
         // Frame start uses the pending divisor as it stood before this edge,
         // so a same-cycle load only affects the following frame.
         if (start_frame) div_cur <= div_pend;
         if (div_load) div_pend <= (div_value < DIV_LO) ? DIV_LO : div_value;
      end
   end

endmodule

// File: tb/tb_uart_rx_bps_ctrl.sv
// Directed self-checking bench for uart_rx_bps_ctrl.
module tb_uart_rx_bps_ctrl;

   logic        clk;
   logic        rst;
   logic        uart_rx;
   logic        start;
   logic        div_load;
   logic [15:0] div_value;
   logic        flag;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] div_cur;

   int n_err = 0;
   int n_chk = 0;

   uart_rx_bps_ctrl #(
      .CLK_FREQ     (50_000_000),
      .BAUD_DEFAULT (9600),
      .DIV_W        (16)
   ) dut (
      .CLK_50M       (clk),
      .RST           (rst),
      .UART_RX       (uart_rx),
      .rx_bps_start  (start),
      .div_load      (div_load),
      .div_value     (div_value),
      .rx_bps_flag   (flag),
      .rx_busy       (busy),
      .rx_frame_done (done),
      .rx_frame_err  (err),
      .div_cur       (div_cur)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_div(input logic [15:0] v);
      div_load  = 1'b1;
      div_value = v;
      tick();
      div_load  = 1'b0;
   endtask

   // Serial line level during frame-relative cycle c: start bit, 8 data bits LSB first, stop.
   function automatic logic line_at(input int c, input int div, input logic [7:0] d, input logic s);
      int p;
      p = c / div;
      if (p == 0) return 1'b0;
      if (p <= 8) return d[p-1];
      return s;
   endfunction

   // Runs one frame from IDLE. drop_at/load_at of 0 mean "not used".
   task automatic run_frame(input string tag, input int div, input logic [7:0] data,
                            input logic stop_val, input int drop_at, input int load_at,
                            input logic [15:0] load_val, input int ncyc);
      int  half;
      logic live;
      logic ef, ed, ee;
      half    = div / 2;
      start   = 1'b1;
      uart_rx = line_at(0, div, data, stop_val);
      tick();  // cycle 0 edge
      for (int n = 1; n <= ncyc; n++) begin
         uart_rx   = line_at(n - 1, div, data, stop_val);
         start     = (drop_at != 0 && n > drop_at) ? 1'b0 : 1'b1;
         div_load  = (load_at != 0 && n == load_at + 1);
         div_value = load_val;
         tick();
         live = (drop_at == 0) || (n <= drop_at);
         ef = live && n >= half && ((n - half) % div == 0) && ((n - half) / div < 9);
         ed = live && (n == half + 9 * div + 1) && stop_val;
         ee = live && (n == half + 9 * div + 1) && !stop_val;
         check($sformatf("%s_flag@%0d", tag, n), flag, ef);
         check($sformatf("%s_done@%0d", tag, n), done, ed);
         check($sformatf("%s_err@%0d", tag, n), err, ee);
         check($sformatf("%s_busy@%0d", tag, n), busy, live);
         if (n == 1) check($sformatf("%s_div", tag), div_cur, div);
      end
      start    = 1'b0;
      div_load = 1'b0;
      uart_rx  = 1'b1;
      tick();
      check($sformatf("%s_idle", tag), busy, 1'b0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b1;
      uart_rx   = 1'b1;
      div_load  = 1'b0;
      div_value = '0;

      // Reset held with start high.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_flag", flag, 1'b0);
         check("rst_busy", busy, 1'b0);
         check("rst_done", done, 1'b0);
         check("rst_err", err, 1'b0);
         check("rst_div", div_cur, 16'd5208);
      end
      rst = 1'b0;
      tick();
      check("rel_busy", busy, 1'b1);
      check("rel_div", div_cur, 16'd5208);
      check("rel_flag", flag, 1'b0);
      start = 1'b0;
      tick();
      check("rel_abort", busy, 1'b0);

      // Good frame and framing error at div 8.
      load_div(16'd8);
      run_frame("t2", 8, 8'h55, 1'b1, 0, 0, 16'd0, 80);
      run_frame("t3", 8, 8'hA3, 1'b0, 0, 0, 16'd0, 80);

      // Divisor change mid-frame takes effect on the next frame only.
      run_frame("t4a", 8, 8'h0F, 1'b1, 0, 20, 16'd16, 80);
      check("t4_div_hold", div_cur, 16'd8);
      run_frame("t4b", 16, 8'hC3, 1'b1, 0, 0, 16'd0, 155);

      // Abort mid-frame, then a fresh frame.
      load_div(16'd8);
      run_frame("t5", 8, 8'h55, 1'b1, 30, 0, 16'd0, 40);
      run_frame("t5r", 8, 8'h3C, 1'b1, 0, 0, 16'd0, 80);

      // Load in the same cycle as frame start: old pending value wins.
      start     = 1'b1;
      div_load  = 1'b1;
      div_value = 16'd16;
      tick();
      div_load  = 1'b0;
      check("same_old", div_cur, 16'd8);
      start = 1'b0;
      tick();
      check("same_abort", busy, 1'b0);
      start = 1'b1;
      tick();
      check("same_new", div_cur, 16'd16);
      start = 1'b0;
      tick();

      // Clamp to minimum divisor; request held after done stays in WAIT_REL.
      load_div(16'd2);
      run_frame("t6", 4, 8'h96, 1'b1, 0, 0, 16'd0, 60);

      // Reset mid-frame restores the default pending divisor.
      load_div(16'd8);
      start = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("mrst_pre_busy", busy, 1'b1);
      rst = 1'b1;
      tick();
      check("mrst_busy", busy, 1'b0);
      check("mrst_flag", flag, 1'b0);
      check("mrst_div", div_cur, 16'd5208);
      rst = 1'b0;
      tick();
      check("mrst_start_div", div_cur, 16'd5208);
      check("mrst_start_busy", busy, 1'b1);
      start = 1'b0;
      tick();
      check("mrst_end", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
